otter_pipe_ctrl: RTL
====================

OTTER_PIPE_CTRL -- requirements
Module: otter_pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, pipeline depth (stage 0=F, 1=D, 2=E, NSTAGE-1=W); legal 4..8.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port d_valid  input  1  decode stage holds a real instruction.
REQ-006 SHALL have ports d_rs1, d_rs2, d_rd  input  5 each  decode register addresses.
REQ-007 SHALL have ports d_use_rs1, d_use_rs2, d_regwrite, d_memread  input  1 each  decode instruction attributes.
REQ-008 SHALL have port ex_redirect  input  1  taken branch/jump resolved in E this cycle.
REQ-009 SHALL have ports stall_f, stall_d  output  1 each  hold PC and FD register.
REQ-010 SHALL have ports flush_d, flush_e  output  1 each  bubble FD / DE register on next edge.
REQ-011 SHALL have ports fwd_a, fwd_b  output  $clog2(NSTAGE) each  operand source for E-bound rs1/rs2.
REQ-012 SHALL have port stage_valid  output  NSTAGE-2  valid bits of stages 2..NSTAGE-1.
REQ-013 SHALL have ports stall_cnt, retire_cnt  output  CNT_W each  performance counters.

Function
REQ-014 SHALL track per stage 2..NSTAGE-1 an entry {valid, rd, regwrite, memread}; entries shift one stage per cycle, last-stage entry discarded.
REQ-015 On each edge stage 2 SHALL load the decode attributes with valid=d_valid, or a bubble (valid=0) when stall_d or ex_redirect is high.
REQ-016 A stage s "writes r" SHALL mean valid & regwrite & rd==r & r!=0; x0 never causes a hazard or forward.
REQ-017 fwd_a SHALL be 0 (register file) when no stage 2..NSTAGE-2 writes d_rs1 with d_use_rs1, else the lowest such s (youngest wins); fwd_b likewise for d_rs2; combinational.
REQ-018 Last stage SHALL never be a forward source; register file is written in first half-cycle, so reads see it.
REQ-019 Load-use: stage 2 writes a used source and has memread -> stall_f=stall_d=1 for exactly that cycle, bubble into E.
REQ-020 ex_redirect SHALL force flush_d=flush_e=1 and stall_f=stall_d=0 (redirect overrides stall).
REQ-021 All hazard outputs SHALL be 0 when d_valid=0.
REQ-022 stall_cnt SHALL increment each cycle stall_d=1; retire_cnt each cycle last-stage valid=1; both wrap to 0 at 2^CNT_W.

Reset
REQ-023 RST SHALL asynchronously clear all entry valid bits, stage_valid, stall_cnt, retire_cnt to 0; fwd_a/fwd_b=0, stall/flush outputs 0 while RST high.
REQ-024 Reset mid-stall SHALL drop the stall immediately; first edge after RST release behaves as empty pipe.

Configuration
REQ-025 Macro OTTER_PIPE_FWD_EN SHALL enable forwarding per REQ-017/019.
REQ-026 Without OTTER_PIPE_FWD_EN, fwd_a=fwd_b=0 always and stall_d=1 while any stage 2..NSTAGE-2 writes a used source (regardless of memread).

Structure
REQ-027 Package otter_pipe_pkg SHALL hold stage index constants (STG_F, STG_D, STG_E), FWD_RF=0 constant, and the packed stage-entry typedef.
REQ-028 Sub-module otter_fwd_prio SHALL implement the per-operand match and lowest-stage priority select; instantiated twice.

Verification
REQ-029 NSTAGE=5, FWD_EN: addi x5 then add x6,x5,x5 back-to-back -> fwd_a=fwd_b=2, no stall.
REQ-030 lw x7 then add x8,x7,x0 -> one cycle stall_d=1, bubble in E, then fwd_a=3; stall_cnt=1.
REQ-031 addi x0,... then use x0 -> fwd_a=0, no stall.
REQ-032 ex_redirect=1 coincident with load-use -> flush_d=flush_e=1, stall_d=0, stall_cnt unchanged.
REQ-033 No FWD_EN, addi x5 then use x5 -> stall_d=1 for 2 cycles, then fwd_a=0.
REQ-034 RST asserted during stall with 3 valid stages -> stage_valid=0, counters=0 without waiting for CLK; CNT_W=4, 16 retires -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared definitions for the OTTER pipeline hazard controller: stage indices,
// the forward-source encoding for "register file", and the per-stage entry
// that tracks what each in-flight instruction will write.
package otter_pipe_pkg;

    localparam int STG_F  = 0;
    localparam int STG_D  = 1;
    localparam int STG_E  = 2;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_ent_t;

    // True when entry e will write architectural register r (x0 never counts)
    function automatic logic ent_writes(input stage_ent_t e, input logic [4:0] r);
        return e.valid && e.regwrite && (e.rd == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/otter_fwd_prio.sv
// Per-operand hazard match: finds the youngest stage E..W-1 writing src.
// Latency: purely combinational.
// Backpressure: none; hazard asserts when this operand needs the decode stage held.
// With OTTER_PIPE_FWD_EN the youngest writer is selected as the forward source and only
// a load still in E raises a hazard; without it sel stays at the register file
// and any pending writer raises a hazard.
module otter_fwd_prio
    import otter_pipe_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int FW     = $clog2(NSTAGE)
) (
    input  stage_ent_t [NSTAGE-2:STG_E] ents,
    input  logic [4:0]                  src,
    input  logic                        use_src,
    output logic [FW-1:0]               sel,
    output logic                        hazard
);

`ifdef OTTER_PIPE_FWD_EN
    logic sel_mem;

    // Scan oldest to youngest so the youngest matching stage wins
    always_comb begin
        sel     = FW'(FWD_RF);
        sel_mem = 1'b0;
        for (int s = NSTAGE - 2; s >= STG_E; s--) begin
            if (use_src && ent_writes(ents[s], src)) begin
                sel     = FW'(s);
                sel_mem = ents[s].memread;
            end
        end
    end

    // Load data is not available until after E, so a load sitting in E cannot forward
    assign hazard = (sel == FW'(STG_E)) && sel_mem;
`else
    logic hit;

    // Any pending writer of the source blocks decode until it reaches W
    always_comb begin
        hit = 1'b0;
        for (int s = STG_E; s <= NSTAGE - 2; s++) begin
            if (use_src && ent_writes(ents[s], src)) begin
                hit = 1'b1;
            end
        end
    end

    assign sel    = FW'(FWD_RF);
    assign hazard = hit;
`endif

endmodule

// File: rtl/otter_pipe_ctrl.sv
// OTTER pipeline control: tracks in-flight writers, drives stall/flush/forward selects and perf counters.
// Latency: hazard/forward outputs combinational from decode inputs; stage tracking advances one stage per CLK.
// Backpressure: stall_f/stall_d hold fetch/decode on a data hazard; ex_redirect flushes and overrides stall.
// Build option: define OTTER_PIPE_FWD_EN to enable operand forwarding (default build interlocks instead).
module otter_pipe_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      d_valid,
    input  logic [4:0]                d_rs1,
    input  logic [4:0]                d_rs2,
    input  logic [4:0]                d_rd,
    input  logic                      d_use_rs1,
    input  logic                      d_use_rs2,
    input  logic                      d_regwrite,
    input  logic                      d_memread,
    input  logic                      ex_redirect,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic [$clog2(NSTAGE)-1:0] fwd_a,
    output logic [$clog2(NSTAGE)-1:0] fwd_b,
    output logic [NSTAGE-3:0]         stage_valid,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          retire_cnt
);

    localparam int FW = $clog2(NSTAGE);

    // Stages E..W-1 keep full entries (they can be forward sources); W only needs valid
    stage_ent_t [NSTAGE-2:STG_E] pipe;
    logic                        w_vld;
    stage_ent_t                  d_ent;
    logic [FW-1:0]               sel_a;
    logic [FW-1:0]               sel_b;
    logic                        haz_a;
    logic                        haz_b;
    logic                        hold;

    assign d_ent = '{valid: d_valid, rd: d_rd, regwrite: d_regwrite, memread: d_memread};

    otter_fwd_prio #(.NSTAGE(NSTAGE), .FW(FW)) u_fwd_a (
        .ents    (pipe),
        .src     (d_rs1),
        .use_src (d_use_rs1),
        .sel     (sel_a),
        .hazard  (haz_a)
    );

    otter_fwd_prio #(.NSTAGE(NSTAGE), .FW(FW)) u_fwd_b (
        .ents    (pipe),
        .src     (d_rs2),
        .use_src (d_use_rs2),
        .sel     (sel_b),
        .hazard  (haz_b)
    );

    // Hazard outputs: quiet in reset or with an empty decode slot; redirect beats stall
    always_comb begin
        hold    = !RST && d_valid && !ex_redirect && (haz_a || haz_b);
        stall_f = hold;
        stall_d = hold;
        flush_d = !RST && ex_redirect;
        flush_e = !RST && ex_redirect;
        fwd_a   = (!RST && d_valid) ? sel_a : FW'(FWD_RF);
        fwd_b   = (!RST && d_valid) ? sel_b : FW'(FWD_RF);
    end

    // Advance stage entries; E takes a bubble when decode is held or the path is redirected
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe  <= '0;
            w_vld <= 1'b0;
        end else begin
            pipe[STG_E] <= (hold || ex_redirect) ? stage_ent_t'('0) : d_ent;
            for (int s = STG_E + 1; s <= NSTAGE - 2; s++) begin
                pipe[s] <= pipe[s-1];
            end
            w_vld <= pipe[NSTAGE-2].valid;
        end
    end

    // Expose per-stage valid bits, stage E at bit 0
    always_comb begin
        stage_valid = '0;
        for (int s = STG_E; s <= NSTAGE - 2; s++) begin
            stage_valid[s-STG_E] = pipe[s].valid;
        end
        stage_valid[NSTAGE-3] = w_vld;
    end

    // Performance counters wrap naturally at 2^CNT_W
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (hold) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (w_vld) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

endmodule
